// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: requester IDs and
// the request/response message layouts carried on the memory port.
package mem_port_arbiter_pkg;

   typedef logic [0:0] mem_arb_id_t;

   localparam mem_arb_id_t MEM_ARB_ID_FETCH = 1'b0;
   localparam mem_arb_id_t MEM_ARB_ID_LSU   = 1'b1;

   typedef enum logic [0:0] {
      MEM_MSG_READ  = 1'b0,
      MEM_MSG_WRITE = 1'b1
   } mem_msg_op_e;

   typedef struct packed {
      mem_msg_op_e op;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } mem_req_msg_t;

   typedef struct packed {
      mem_msg_op_e op;
      logic [7:0]  opaque;
      logic [31:0] data;
   } mem_resp_msg_t;

   localparam int MEM_REQ_MSG_W  = $bits(mem_req_msg_t);
   localparam int MEM_RESP_MSG_W = $bits(mem_resp_msg_t);

endpackage

// File: rtl/mem_port_arbiter_id_fifo.sv
// In-order FIFO of requester IDs: one entry per request accepted by memory
// and not yet answered; the head names the owner of the next response.
module mem_port_arbiter_id_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int P_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  logic [0:0] i_push_id,
   input  logic       i_pop,
   output logic [0:0] o_head_id,
   output logic       o_full,
   output logic       o_empty
);

   localparam int PTR_W = $clog2(P_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   mem_arb_id_t      r_ids [P_DEPTH];

   // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ID storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < P_DEPTH; i++) r_ids[i] <= MEM_ARB_ID_FETCH;
      end else if (i_push) begin
         r_ids[r_wr_ptr] <= i_push_id;
      end
   end

   assign o_head_id = r_ids[r_rd_ptr];
   assign o_full    = (r_count == CNT_W'(P_DEPTH));
   assign o_empty   = (r_count == CNT_W'(0));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (port 0) and load/store (port 1):
// round-robin grant with a hold-until-accepted lock, in-order response steering.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int p_max_inflight = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_req0_req_val,
   output logic                      o_req0_req_rdy,
   input  logic [MEM_REQ_MSG_W-1:0]  i_req0_req_msg,
   output logic                      o_req0_resp_val,
   input  logic                      i_req0_resp_rdy,
   output logic [MEM_RESP_MSG_W-1:0] o_req0_resp_msg,
   input  logic                      i_req1_req_val,
   output logic                      o_req1_req_rdy,
   input  logic [MEM_REQ_MSG_W-1:0]  i_req1_req_msg,
   output logic                      o_req1_resp_val,
   input  logic                      i_req1_resp_rdy,
   output logic [MEM_RESP_MSG_W-1:0] o_req1_resp_msg,
   output logic                      o_mem_req_val,
   input  logic                      i_mem_req_rdy,
   output logic [MEM_REQ_MSG_W-1:0]  o_mem_req_msg,
   input  logic                      i_mem_resp_val,
   output logic                      o_mem_resp_rdy,
   input  logic [MEM_RESP_MSG_W-1:0] i_mem_resp_msg
);

   mem_arb_id_t r_prio;
   logic        r_lock;
   mem_arb_id_t r_lock_id;
   mem_arb_id_t w_grant;
   mem_arb_id_t w_head_id;
   logic        w_full;
   logic        w_empty;
   logic        w_issue_ok;
   logic        w_sel_val;
   logic        w_req_xfer;
   logic        w_resp_val;
   logic        w_sel_resp_rdy;
   logic        w_resp_xfer;

   // Grant selection: a stalled offer keeps the port, otherwise round-robin.
   always_comb begin
      w_grant = r_prio;
      if (r_lock) begin
         w_grant = r_lock_id;
      end else if (i_req0_req_val && !i_req1_req_val) begin
         w_grant = MEM_ARB_ID_FETCH;
      end else if (i_req1_req_val && !i_req0_req_val) begin
         w_grant = MEM_ARB_ID_LSU;
      end else begin
         w_grant = r_prio;
      end
   end

   // Full blocks issue outright, even when a response frees a slot this cycle.
   assign w_issue_ok     = rst && !w_full;
   assign w_sel_val      = (w_grant == MEM_ARB_ID_LSU) ? i_req1_req_val : i_req0_req_val;
   assign o_mem_req_val  = w_issue_ok && w_sel_val;
   assign o_mem_req_msg  = (w_grant == MEM_ARB_ID_LSU) ? i_req1_req_msg : i_req0_req_msg;
   assign o_req0_req_rdy = w_issue_ok && i_mem_req_rdy && (w_grant == MEM_ARB_ID_FETCH);
   assign o_req1_req_rdy = w_issue_ok && i_mem_req_rdy && (w_grant == MEM_ARB_ID_LSU);
   assign w_req_xfer     = o_mem_req_val && i_mem_req_rdy;

   // Priority flips away from each winner; lock holds an offered-but-stalled grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prio    <= MEM_ARB_ID_FETCH;
         r_lock    <= 1'b0;
         r_lock_id <= MEM_ARB_ID_FETCH;
      end else if (w_req_xfer) begin
         r_prio <= ~w_grant;
         r_lock <= 1'b0;
      end else if (o_mem_req_val) begin
         r_lock    <= 1'b1;
         r_lock_id <= w_grant;
      end
   end

   // An empty FIFO means the response predates reset: accept and drop it.
   assign w_resp_val      = rst && i_mem_resp_val && !w_empty;
   assign o_req0_resp_val = w_resp_val && (w_head_id == MEM_ARB_ID_FETCH);
   assign o_req1_resp_val = w_resp_val && (w_head_id == MEM_ARB_ID_LSU);
   assign o_req0_resp_msg = i_mem_resp_msg;
   assign o_req1_resp_msg = i_mem_resp_msg;
   assign w_sel_resp_rdy  = (w_head_id == MEM_ARB_ID_LSU) ? i_req1_resp_rdy : i_req0_resp_rdy;
   assign o_mem_resp_rdy  = rst && (w_empty || w_sel_resp_rdy);
   assign w_resp_xfer     = w_resp_val && w_sel_resp_rdy;

   mem_port_arbiter_id_fifo #(
      .P_DEPTH (p_max_inflight)
   ) u_id_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_req_xfer),
      .i_push_id (w_grant),
      .i_pop     (w_resp_xfer),
      .o_head_id (w_head_id),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester source queues, a latency-1 memory model,
// a grant/lock reference model and a response scoreboard.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int          MAX_INF  = 4;
   localparam logic [31:0] RESP_XOR = 32'hA5A5_0000;

   typedef struct { logic [0:0] id; logic [31:0] data; } exp_resp_t;
   typedef struct { mem_resp_msg_t msg; int rdy_cyc; } mem_ent_t;

   logic          clk, rst;
   logic          i_req0_req_val, o_req0_req_rdy, o_req0_resp_val, i_req0_resp_rdy;
   logic          i_req1_req_val, o_req1_req_rdy, o_req1_resp_val, i_req1_resp_rdy;
   logic          o_mem_req_val, i_mem_req_rdy, i_mem_resp_val, o_mem_resp_rdy;
   mem_req_msg_t  i_req0_req_msg, i_req1_req_msg, o_mem_req_msg;
   mem_resp_msg_t o_req0_resp_msg, o_req1_resp_msg, i_mem_resp_msg;

   mem_req_msg_t src0_q[$];
   mem_req_msg_t src1_q[$];
   exp_resp_t    exp_resp_q[$];
   mem_ent_t     mem_out_q[$];
   logic [0:0]   grant_log[$];
   int           n_checks, n_errors, cyc, n_mem_xfer, n_rx0, n_rx1, resp_budget;
   logic [0:0]   t_prio, t_lock_id;
   logic         t_lock;

   mem_port_arbiter #(.p_max_inflight(MAX_INF)) dut (
      .clk(clk), .rst(rst),
      .i_req0_req_val(i_req0_req_val), .o_req0_req_rdy(o_req0_req_rdy), .i_req0_req_msg(i_req0_req_msg),
      .o_req0_resp_val(o_req0_resp_val), .i_req0_resp_rdy(i_req0_resp_rdy), .o_req0_resp_msg(o_req0_resp_msg),
      .i_req1_req_val(i_req1_req_val), .o_req1_req_rdy(o_req1_req_rdy), .i_req1_req_msg(i_req1_req_msg),
      .o_req1_resp_val(o_req1_resp_val), .i_req1_resp_rdy(i_req1_resp_rdy), .o_req1_resp_msg(o_req1_resp_msg),
      .o_mem_req_val(o_mem_req_val), .i_mem_req_rdy(i_mem_req_rdy), .o_mem_req_msg(o_mem_req_msg),
      .i_mem_resp_val(i_mem_resp_val), .o_mem_resp_rdy(o_mem_resp_rdy), .i_mem_resp_msg(i_mem_resp_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic mem_req_msg_t make_req(input logic [0:0] id, input logic [31:0] addr);
      mem_req_msg_t m;
      m.op     = addr[2] ? MEM_MSG_WRITE : MEM_MSG_READ;
      m.opaque = {7'b0000000, id};
      m.addr   = addr;
      m.strb   = 4'hF;
      m.data   = ~addr;
      return m;
   endfunction

   task automatic drive();
      i_req0_req_val = 1'b0;
      i_req0_req_msg = '0;
      i_req1_req_val = 1'b0;
      i_req1_req_msg = '0;
      if (src0_q.size() > 0) begin
         i_req0_req_val = 1'b1;
         i_req0_req_msg = src0_q[0];
      end
      if (src1_q.size() > 0) begin
         i_req1_req_val = 1'b1;
         i_req1_req_msg = src1_q[0];
      end
      i_mem_resp_val = 1'b0;
      i_mem_resp_msg = '0;
      if (mem_out_q.size() > 0 && resp_budget > 0 && mem_out_q[0].rdy_cyc <= cyc) begin
         i_mem_resp_val = 1'b1;
         i_mem_resp_msg = mem_out_q[0].msg;
      end
   endtask

   // One clock: check outputs at negedge against the model, then advance sources/memory.
   task automatic cycle();
      mem_req_msg_t  m;
      mem_resp_msg_t r;
      exp_resp_t     e;
      mem_ent_t      me;
      logic [0:0]    eg;
      logic [31:0]   exp_addr;
      logic          v0, v1, exp_val, full_s, x0, x1, rxm;
      @(negedge clk);
      if (!rst) begin
         check_val("rst_mem_req_val", 64'(o_mem_req_val), 64'(0));
         check_val("rst_req0_rdy", 64'(o_req0_req_rdy), 64'(0));
         check_val("rst_req1_rdy", 64'(o_req1_req_rdy), 64'(0));
         check_val("rst_req0_resp_val", 64'(o_req0_resp_val), 64'(0));
         check_val("rst_req1_resp_val", 64'(o_req1_resp_val), 64'(0));
         check_val("rst_mem_resp_rdy", 64'(o_mem_resp_rdy), 64'(0));
      end else begin
         full_s = (exp_resp_q.size() >= MAX_INF);
         v0 = i_req0_req_val;
         v1 = i_req1_req_val;
         if (i_mem_resp_val) begin
            if (exp_resp_q.size() == 0) begin
               check_val("stale_v0", 64'(o_req0_resp_val), 64'(0));
               check_val("stale_v1", 64'(o_req1_resp_val), 64'(0));
               check_val("stale_rdy", 64'(o_mem_resp_rdy), 64'(1));
            end else begin
               e = exp_resp_q[0];
               check_val("route_v0", 64'(o_req0_resp_val), 64'(e.id == 1'b0));
               check_val("route_v1", 64'(o_req1_resp_val), 64'(e.id == 1'b1));
               check_val("resp_rdy", 64'(o_mem_resp_rdy),
                         64'((e.id == 1'b1) ? i_req1_resp_rdy : i_req0_resp_rdy));
               if ((e.id == 1'b1) ? i_req1_resp_rdy : i_req0_resp_rdy) begin
                  r = (e.id == 1'b1) ? o_req1_resp_msg : o_req0_resp_msg;
                  check_val("resp_data", 64'(r.data), 64'(e.data));
                  check_val("resp_opaque", 64'(r.opaque), 64'(e.id));
                  void'(exp_resp_q.pop_front());
                  if (e.id == 1'b1) n_rx1++;
                  else n_rx0++;
               end
            end
         end else begin
            check_val("idle_resp_v0", 64'(o_req0_resp_val), 64'(0));
            check_val("idle_resp_v1", 64'(o_req1_resp_val), 64'(0));
         end
         if (t_lock) eg = t_lock_id;
         else if (v0 && !v1) eg = 1'b0;
         else if (v1 && !v0) eg = 1'b1;
         else eg = t_prio;
         exp_val = !full_s && ((eg == 1'b1) ? v1 : v0);
         check_val("mem_req_val", 64'(o_mem_req_val), 64'(exp_val));
         check_val("req0_rdy", 64'(o_req0_req_rdy), 64'(!full_s && i_mem_req_rdy && eg == 1'b0));
         check_val("req1_rdy", 64'(o_req1_req_rdy), 64'(!full_s && i_mem_req_rdy && eg == 1'b1));
         m = o_mem_req_msg;
         exp_addr = 32'h0;
         if (exp_val) begin
            if (eg == 1'b1) exp_addr = src1_q[0].addr;
            else exp_addr = src0_q[0].addr;
            check_val("mem_req_addr", 64'(m.addr), 64'(exp_addr));
            check_val("mem_req_opaque", 64'(m.opaque), 64'(eg));
         end
         if (o_mem_req_val && i_mem_req_rdy) begin
            n_mem_xfer++;
            grant_log.push_back(m.opaque[0:0]);
            if (exp_val) begin
               e.id   = eg;
               e.data = exp_addr ^ RESP_XOR;
               exp_resp_q.push_back(e);
            end
            me.msg.op     = m.op;
            me.msg.opaque = m.opaque;
            me.msg.data   = m.addr ^ RESP_XOR;
            me.rdy_cyc    = cyc + 1;
            mem_out_q.push_back(me);
            t_prio = ~eg;
            t_lock = 1'b0;
         end else if (exp_val) begin
            t_lock    = 1'b1;
            t_lock_id = eg;
         end
      end
      x0  = i_req0_req_val && o_req0_req_rdy;
      x1  = i_req1_req_val && o_req1_req_rdy;
      rxm = i_mem_resp_val && o_mem_resp_rdy;
      @(posedge clk);
      #1;
      cyc++;
      if (x0) void'(src0_q.pop_front());
      if (x1) void'(src1_q.pop_front());
      if (rxm) begin
         void'(mem_out_q.pop_front());
         resp_budget--;
      end
      drive();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      logic busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < max_cyc) begin
         cycle();
         n++;
         busy = (src0_q.size() > 0) || (src1_q.size() > 0) || (exp_resp_q.size() > 0);
      end
      check_val("drain_timeout", 64'(busy), 64'(0));
   endtask

   task automatic do_reset();
      src0_q.delete();
      src1_q.delete();
      drive();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      exp_resp_q.delete();
      t_prio    = 1'b0;
      t_lock    = 1'b0;
      t_lock_id = 1'b0;
      drive();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, r0, r1, g;
      n_checks = 0; n_errors = 0; cyc = 0; n_mem_xfer = 0; n_rx0 = 0; n_rx1 = 0;
      resp_budget = 1000;
      t_prio = 1'b0; t_lock = 1'b0; t_lock_id = 1'b0;
      rst = 1'b0;
      i_mem_req_rdy = 1'b1; i_req0_resp_rdy = 1'b1; i_req1_resp_rdy = 1'b1;
      i_req0_req_val = 1'b1; i_req1_req_val = 1'b1; i_mem_resp_val = 1'b1;
      i_req0_req_msg = make_req(1'b0, 32'h0000_0040);
      i_req1_req_msg = make_req(1'b1, 32'h0000_1040);
      i_mem_resp_msg = '0;
      cycle();
      do_reset();

      // Contention from reset: strict alternation starting with fetch.
      grant_log.delete();
      src0_q.push_back(make_req(1'b0, 32'h0000_0100));
      src0_q.push_back(make_req(1'b0, 32'h0000_0104));
      src1_q.push_back(make_req(1'b1, 32'h0000_0800));
      src1_q.push_back(make_req(1'b1, 32'h0000_0804));
      drive();
      drain(40);
      check_val("cont_len", 64'(grant_log.size()), 64'(4));
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check_val($sformatf("cont_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

      // Single requester streaming at full rate.
      n0 = n_mem_xfer; r0 = n_rx0; r1 = n_rx1;
      src0_q.push_back(make_req(1'b0, 32'h0000_0200));
      src0_q.push_back(make_req(1'b0, 32'h0000_0204));
      src0_q.push_back(make_req(1'b0, 32'h0000_0208));
      drive();
      repeat (3) cycle();
      check_val("single_xfers", 64'(n_mem_xfer - n0), 64'(3));
      drain(20);
      check_val("single_rx0", 64'(n_rx0 - r0), 64'(3));
      check_val("single_rx1", 64'(n_rx1 - r1), 64'(0));

      // Backpressure: req1's offer holds the port while req0 arrives.
      g = grant_log.size();
      i_mem_req_rdy = 1'b0;
      src1_q.push_back(make_req(1'b1, 32'h0000_1000));
      drive();
      cycle();
      src0_q.push_back(make_req(1'b0, 32'h0000_0300));
      drive();
      repeat (2) cycle();
      i_mem_req_rdy = 1'b1;
      drive();
      drain(20);
      check_val("lock_len", 64'(grant_log.size() - g), 64'(2));
      if (grant_log.size() >= g + 2) begin
         check_val("lock_first", 64'(grant_log[g]), 64'(1));
         check_val("lock_second", 64'(grant_log[g+1]), 64'(0));
      end

      // Response stall with req1 at the FIFO head.
      i_req1_resp_rdy = 1'b0;
      src1_q.push_back(make_req(1'b1, 32'h0000_1100));
      drive();
      cycle();
      src0_q.push_back(make_req(1'b0, 32'h0000_0240));
      drive();
      r0 = n_rx0 + n_rx1;
      repeat (2) cycle();
      check_val("stall_no_pop", 64'(n_rx0 + n_rx1 - r0), 64'(0));
      i_req1_resp_rdy = 1'b1;
      drive();
      drain(20);

      // Full: responses withheld, then exactly one released.
      resp_budget = 0;
      for (int i = 0; i < 6; i++) begin
         src0_q.push_back(make_req(1'b0, 32'h0000_0600 + 32'(4 * i)));
         src1_q.push_back(make_req(1'b1, 32'h0000_1600 + 32'(4 * i)));
      end
      drive();
      n0 = n_mem_xfer;
      repeat (8) cycle();
      check_val("full_xfers", 64'(n_mem_xfer - n0), 64'(4));
      resp_budget = 1;
      drive();
      repeat (4) cycle();
      check_val("full_release", 64'(n_mem_xfer - n0), 64'(5));
      resp_budget = 1000;
      drive();
      drain(60);

      // Mid-flight reset: two outstanding, their responses arrive stale.
      resp_budget = 0;
      src0_q.push_back(make_req(1'b0, 32'h0000_0400));
      src1_q.push_back(make_req(1'b1, 32'h0000_1400));
      drive();
      repeat (2) cycle();
      check_val("mid_outstanding", 64'(mem_out_q.size()), 64'(2));
      do_reset();
      resp_budget = 1000;
      drive();
      repeat (4) cycle();
      check_val("stale_drained", 64'(mem_out_q.size()), 64'(0));
      grant_log.delete();
      src0_q.push_back(make_req(1'b0, 32'h0000_0500));
      src1_q.push_back(make_req(1'b1, 32'h0000_1500));
      drive();
      drain(20);
      check_val("post_rst_len", 64'(grant_log.size()), 64'(2));
      if (grant_log.size() >= 2) begin
         check_val("post_rst_first", 64'(grant_log[0]), 64'(0));
         check_val("post_rst_second", 64'(grant_log[1]), 64'(1));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
